finder_center_locator: RTL
==========================

// Module: finder_center_locator
// PURPOSE
//  Parametrised finder-pattern center locator for the QR pipeline. Splits the frame into a
//  ZONES_X x ZONES_Y grid, scans each zone for pixels where horizontal and vertical pattern
//  hits cross, reads them from the binarised frame buffer, and emits the midpoint of the
//  crossings of every zone that is majority-black. Sits after the pattern scanners, before corner/affine solve.
// PARAMETERS
//  WIDTH        480  frame width in pixels
//  HEIGHT       480  frame height in pixels
//  COORD_W      9    coordinate width; must satisfy 2**COORD_W >= max(WIDTH,HEIGHT)
//  ZONES_X      3    zone columns (>=1)
//  ZONES_Y      3    zone rows (>=1)
//  MAX_CENTERS  3    center slots; expected center count
//  READ_LAT     2    frame-buffer read latency, cycles from address_out to pixel_in
//  THRESH_NUM   5    majority threshold numerator (black*2**THRESH_SHIFT > total*THRESH_NUM)
//  THRESH_SHIFT 3    majority threshold denominator exponent (5/8 default)
// PORTS
//  clk_in          in   1                       system clock
//  rst_in          in   1                       synchronous active-high reset
//  start_in        in   1                       begin scan; honoured only when idle
//  horz_patterns   in   WIDTH                   per-column horizontal pattern hit flags
//  vert_patterns   in   HEIGHT                  per-row vertical pattern hit flags
//  bound_x         in   (ZONES_X-1)xCOORD_W     interior zone x boundaries, ascending
//  bound_y         in   (ZONES_Y-1)xCOORD_W     interior zone y boundaries, ascending
//  pixel_in        in   1                       frame-buffer data, 1 = white
//  address_out     out  $clog2(WIDTH*HEIGHT)    read address, x + y*WIDTH (absolute)
//  busy_out        out  1                       high from accepted start until done_out
//  centers_x/_y    out  MAX_CENTERSxCOORD_W     absolute center coordinates
//  center_count    out  $clog2(MAX_CENTERS+1)   centers written this scan
//  done_out        out  1                       one-cycle pulse when scan completes
//  overflow_err    out  1                       a qualifying zone found with all slots full
//  underflow_err   out  1                       scan ended with center_count < MAX_CENTERS
// BEHAVIOUR
//  - Reset: state IDLE; all outputs, counters, centers, errors = 0. Reset mid-scan aborts cleanly.
//  - Clock and reset are clk_in / rst_in; one clock, reset synchronous active-high.
//  - start_in in IDLE: latch horz/vert/bound_x/bound_y into registers, clear centers, count,
//    errors; busy_out=1 next cycle. start_in while busy is ignored. Inputs may change after start.
//  - Zone (i,j): x in [bx[i-1], bx[i]] inclusive, bx[-1]=0, bx[ZONES_X-1]=WIDTH-1; same for y.
//    Boundary pixels belong to both neighbours. A zone with max<min is skipped with no reads.
//  - Zone order: x-major within row (zone_x 0..ZONES_X-1, then zone_y++). Pixel order raster within zone.
//  - States: IDLE -> SCAN -> (WAIT x READ_LAT -> SAMPLE -> SCAN) ... -> EVAL -> SCAN|DONE -> IDLE.
//  - SCAN: one pixel per cycle. Non-candidate (horz[x]&vert[y]==0): advance, no read.
//    Candidate: drive address_out, record end=(x,y); first candidate of zone also records start.
//  - SAMPLE: pixel_in==1 -> white++, else black++; advance. Last pixel of zone -> EVAL.
//  - EVAL (1 cycle): total=black+white. Qualifies iff total>0 and
//    (black<<THRESH_SHIFT) > total*THRESH_NUM, computed without truncation.
//    Qualifying: if count<MAX_CENTERS write slot[count] = ((start+end)>>1) + zone_min per axis,
//    using COORD_W+1 bit intermediate, count++; else set overflow_err (sticky, no write).
//    Then clear counters/start/end and advance zone; after last zone -> DONE.
//  - DONE: done_out=1 for exactly one cycle, busy_out=0, underflow_err set if count<MAX_CENTERS;
//    next state IDLE. Centers, count, errors hold until next accepted start or reset.
//  - Counters sized $clog2(WIDTH*HEIGHT+1); never wrap within a frame.
// STRUCTURE
//  - qr_pkg: locator state enum, coord_t (COORD_W), default WIDTH/HEIGHT/READ_LAT constants.
//  - Sub-module zone_majority_acc: black/white counters, start/end capture, threshold compare,
//    midpoint calc; cleared by FSM on EVAL. Top holds FSM, zone/pixel walkers, address, slots.
// TESTING
//  - 3x3 zones, bounds 160/320, candidates only at (40..60,40..60) all black -> one center (50,50),
//    count=1, underflow_err=1, done_out single pulse.
//  - Three black crossings in zones (0,0),(2,0),(0,2) -> centers in zone order, count=3, no errors.
//  - Zone with 5 black/3 white (=5/8) -> not recorded; 6 black/2 white -> recorded.
//  - Four qualifying zones, MAX_CENTERS=3 -> first three stored, overflow_err=1, count=3.
//  - All pattern flags 0 -> no reads, count=0, underflow_err=1, done after every zone walked.
//  - rst_in mid-scan then start_in: all outputs 0 after reset; second scan matches clean run;
//    start_in pulses while busy have no effect.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared types and default geometry for the QR finder-pattern pipeline.
package qr_pkg;
    localparam int QR_WIDTH    = 480;
    localparam int QR_HEIGHT   = 480;
    localparam int QR_COORD_W  = 9;
    localparam int QR_READ_LAT = 2;

    typedef logic [QR_COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        LOC_IDLE,
        LOC_SCAN,
        LOC_WAIT,
        LOC_SAMPLE,
        LOC_EVAL,
        LOC_DONE
    } loc_state_e;
endpackage

// File: rtl/zone_majority_acc.sv
// Per-zone black/white tally, first/last crossing capture, majority test and
// midpoint of the crossings translated back to absolute coordinates.
module zone_majority_acc #(
    parameter int COORD_W      = 9,
    parameter int CNT_W        = 18,
    parameter int THRESH_NUM   = 5,
    parameter int THRESH_SHIFT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clr,
    input  logic               cap,
    input  logic [COORD_W-1:0] cap_x,
    input  logic [COORD_W-1:0] cap_y,
    input  logic               smp,
    input  logic               smp_white,
    input  logic [COORD_W-1:0] lo_x,
    input  logic [COORD_W-1:0] lo_y,
    output logic               qualify,
    output logic [COORD_W-1:0] mid_x,
    output logic [COORD_W-1:0] mid_y
);
    // Wide enough that black<<SHIFT and total*NUM never truncate.
    localparam int CMP_W = CNT_W + 1 + THRESH_SHIFT + $clog2(THRESH_NUM + 1);

    logic [CNT_W-1:0]   black, white;
    logic               have_start;
    logic [COORD_W-1:0] sx, sy, ex, ey;
    logic [CMP_W-1:0]   total_w;

    always_ff @(posedge clk_in) begin
        if (rst_in || clr) begin
            black      <= '0;
            white      <= '0;
            have_start <= 1'b0;
            sx <= '0; sy <= '0; ex <= '0; ey <= '0;
        end else begin
            if (cap) begin
                if (!have_start) begin
                    sx <= cap_x;
                    sy <= cap_y;
                    have_start <= 1'b1;
                end
                ex <= cap_x;
                ey <= cap_y;
            end
            if (smp) begin
                if (smp_white) white <= white + CNT_W'(1);
                else           black <= black + CNT_W'(1);
            end
        end
    end

    always_comb begin
        total_w = CMP_W'(black) + CMP_W'(white);
        qualify = (total_w != '0) &&
                  ((CMP_W'(black) << THRESH_SHIFT) > (total_w * CMP_W'(THRESH_NUM)));
        mid_x   = COORD_W'((({1'b0, sx} + {1'b0, ex}) >> 1) + {1'b0, lo_x});
        mid_y   = COORD_W'((({1'b0, sy} + {1'b0, ey}) >> 1) + {1'b0, lo_y});
    end
endmodule

// File: rtl/finder_center_locator.sv
// Walks the zone grid pixel by pixel, reads frame-buffer pixels at pattern
// crossings (READ_LAT >= 1) and stores the midpoint of each majority-black zone.
module finder_center_locator import qr_pkg::*; #(
    parameter int WIDTH        = QR_WIDTH,
    parameter int HEIGHT       = QR_HEIGHT,
    parameter int COORD_W      = QR_COORD_W,
    parameter int ZONES_X      = 3,
    parameter int ZONES_Y      = 3,
    parameter int MAX_CENTERS  = 3,
    parameter int READ_LAT     = QR_READ_LAT,
    parameter int THRESH_NUM   = 5,
    parameter int THRESH_SHIFT = 3
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic                                                start_in,
    input  logic [WIDTH-1:0]                                    horz_patterns,
    input  logic [HEIGHT-1:0]                                   vert_patterns,
    input  logic [((ZONES_X > 1) ? ZONES_X-1 : 1)-1:0][COORD_W-1:0] bound_x,
    input  logic [((ZONES_Y > 1) ? ZONES_Y-1 : 1)-1:0][COORD_W-1:0] bound_y,
    input  logic                                                pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]                     address_out,
    output logic                                                busy_out,
    output logic [MAX_CENTERS-1:0][COORD_W-1:0]                 centers_x,
    output logic [MAX_CENTERS-1:0][COORD_W-1:0]                 centers_y,
    output logic [$clog2(MAX_CENTERS+1)-1:0]                    center_count,
    output logic                                                done_out,
    output logic                                                overflow_err,
    output logic                                                underflow_err
);
    localparam int AW    = $clog2(WIDTH*HEIGHT);
    localparam int CNT_W = $clog2(WIDTH*HEIGHT+1);
    localparam int NBX   = (ZONES_X > 1) ? ZONES_X-1 : 1;
    localparam int NBY   = (ZONES_Y > 1) ? ZONES_Y-1 : 1;
    localparam int ZXW   = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int ZYW   = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;
    localparam int CCW   = $clog2(MAX_CENTERS+1);
    localparam int WLW   = $clog2(READ_LAT+1);

    loc_state_e                state, state_nxt;
    logic [WIDTH-1:0]          horz_r;
    logic [HEIGHT-1:0]         vert_r;
    logic [NBX-1:0][COORD_W-1:0] bx_r;
    logic [NBY-1:0][COORD_W-1:0] by_r;
    logic [ZXW-1:0]            zone_x;
    logic [ZYW-1:0]            zone_y;
    logic [COORD_W-1:0]        px, py, x_lo, x_hi, y_lo, y_hi;
    logic [WLW-1:0]            wait_cnt;
    logic                      cand, last_px, zone_empty, last_zone, start_acc;
    logic                      pix_adv, zone_adv, cap, smp, eval;
    logic                      qualify, wr, ovf, enter_done;
    logic [COORD_W-1:0]        mid_x, mid_y;
    logic [CCW-1:0]            count_nxt;

    // Zone limits: neighbouring zones share their boundary row/column.
    always_comb begin
        x_lo = '0;
        x_hi = COORD_W'(WIDTH-1);
        for (int i = 0; i < ZONES_X-1; i++) begin
            if (int'(zone_x) == i+1) x_lo = bx_r[i];
            if (int'(zone_x) == i)   x_hi = bx_r[i];
        end
        y_lo = '0;
        y_hi = COORD_W'(HEIGHT-1);
        for (int j = 0; j < ZONES_Y-1; j++) begin
            if (int'(zone_y) == j+1) y_lo = by_r[j];
            if (int'(zone_y) == j)   y_hi = by_r[j];
        end
    end

    assign cand       = horz_r[px] & vert_r[py];
    assign last_px    = (px == x_hi) && (py == y_hi);
    assign zone_empty = (x_hi < x_lo) || (y_hi < y_lo);
    assign last_zone  = (zone_x == ZXW'(ZONES_X-1)) && (zone_y == ZYW'(ZONES_Y-1));
    assign start_acc  = (state == LOC_IDLE) && start_in;
    assign busy_out   = (state != LOC_IDLE) && (state != LOC_DONE);
    assign done_out   = (state == LOC_DONE);

    always_comb begin
        state_nxt = state;
        pix_adv   = 1'b0;
        zone_adv  = 1'b0;
        cap       = 1'b0;
        smp       = 1'b0;
        eval      = 1'b0;
        case (state)
            LOC_IDLE: if (start_in) state_nxt = LOC_SCAN;
            LOC_SCAN: begin
                if (zone_empty) begin
                    zone_adv  = 1'b1;
                    state_nxt = last_zone ? LOC_DONE : LOC_SCAN;
                end else if (cand) begin
                    cap       = 1'b1;
                    state_nxt = LOC_WAIT;
                end else if (last_px) begin
                    state_nxt = LOC_EVAL;
                end else begin
                    pix_adv = 1'b1;
                end
            end
            LOC_WAIT: if (wait_cnt == WLW'(READ_LAT-1)) state_nxt = LOC_SAMPLE;
            LOC_SAMPLE: begin
                smp = 1'b1;
                if (last_px) state_nxt = LOC_EVAL;
                else begin
                    pix_adv   = 1'b1;
                    state_nxt = LOC_SCAN;
                end
            end
            LOC_EVAL: begin
                eval      = 1'b1;
                zone_adv  = 1'b1;
                state_nxt = last_zone ? LOC_DONE : LOC_SCAN;
            end
            LOC_DONE: state_nxt = LOC_IDLE;
            default:  state_nxt = LOC_IDLE;
        endcase
    end

    assign wr         = eval && qualify && (center_count < CCW'(MAX_CENTERS));
    assign ovf        = eval && qualify && (center_count >= CCW'(MAX_CENTERS));
    assign count_nxt  = wr ? center_count + CCW'(1) : center_count;
    assign enter_done = (state_nxt == LOC_DONE) && (state != LOC_DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= LOC_IDLE;
            horz_r        <= '0;
            vert_r        <= '0;
            bx_r          <= '0;
            by_r          <= '0;
            zone_x        <= '0;
            zone_y        <= '0;
            px            <= '0;
            py            <= '0;
            wait_cnt      <= '0;
            address_out   <= '0;
            centers_x     <= '0;
            centers_y     <= '0;
            center_count  <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                horz_r        <= horz_patterns;
                vert_r        <= vert_patterns;
                bx_r          <= bound_x;
                by_r          <= bound_y;
                zone_x        <= '0;
                zone_y        <= '0;
                px            <= '0;
                py            <= '0;
                address_out   <= '0;
                centers_x     <= '0;
                centers_y     <= '0;
                center_count  <= '0;
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end
            if (cap) begin
                address_out <= AW'(px) + AW'(py) * AW'(WIDTH);
                wait_cnt    <= '0;
            end
            if (state == LOC_WAIT) wait_cnt <= wait_cnt + WLW'(1);
            if (pix_adv) begin
                if (px == x_hi) begin
                    px <= x_lo;
                    py <= py + COORD_W'(1);
                end else begin
                    px <= px + COORD_W'(1);
                end
            end
            // The next zone starts on the current zone's shared boundary.
            if (zone_adv) begin
                if (zone_x == ZXW'(ZONES_X-1)) begin
                    zone_x <= '0;
                    zone_y <= zone_y + ZYW'(1);
                    px     <= '0;
                    py     <= y_hi;
                end else begin
                    zone_x <= zone_x + ZXW'(1);
                    px     <= x_hi;
                    py     <= y_lo;
                end
            end
            for (int k = 0; k < MAX_CENTERS; k++) begin
                if (wr && (int'(center_count) == k)) begin
                    centers_x[k] <= mid_x;
                    centers_y[k] <= mid_y;
                end
            end
            center_count <= start_acc ? '0 : count_nxt;
            if (ovf) overflow_err <= 1'b1;
            if (enter_done) underflow_err <= (count_nxt < CCW'(MAX_CENTERS));
        end
    end

    zone_majority_acc #(
        .COORD_W      (COORD_W),
        .CNT_W        (CNT_W),
        .THRESH_NUM   (THRESH_NUM),
        .THRESH_SHIFT (THRESH_SHIFT)
    ) u_acc (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr       (eval | start_acc),
        .cap       (cap),
        .cap_x     (px - x_lo),
        .cap_y     (py - y_lo),
        .smp       (smp),
        .smp_white (pixel_in),
        .lo_x      (x_lo),
        .lo_y      (y_lo),
        .qualify   (qualify),
        .mid_x     (mid_x),
        .mid_y     (mid_y)
    );
endmodule
